// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and defaults for the tile renderer slice.
//   - fetch_state_e : tile fetch FSM states
//   - rgb332_t      : RGB332 pixel byte
//   - raster / screen defaults and memory address widths
package gpu_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_TOTAL_DEF  = 525;
   localparam int COLUMNS_DEF  = 40;

   localparam int TILE_AW  = 11;
   localparam int ATTR_AW  = 12;
   localparam int COLOR_AW = 4;
   localparam int CELL_W   = ATTR_AW - 1;   // attribute address = {cell, byte}

   typedef logic [7:0] rgb332_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IDX,
      ST_COL,
      ST_ROW,
      ST_FG,
      ST_BG,
      ST_DONE
   } fetch_state_e;

   // Linear cell number for a cell row and column.
   function automatic logic [CELL_W-1:0] cell_index(input logic [4:0] cell_row,
                                                    input logic [6:0] col,
                                                    input int         columns);
      return CELL_W'(int'(cell_row) * columns + int'(col));
   endfunction

endpackage

// File: rtl/tile_fetcher.sv
// tile_fetcher: fetches one 8x8 tile cell row (pattern + fg/bg palette colours)
// through the synchronous read ports of the attribute, tile and colour memories.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start_i, cell_i, row_i: fetch request (ignored unless idle)
//   consume_i             : current registers took the next set; clear next_valid
//   busy_o                : FSM not idle
//   next_valid_o, next_row_o, next_fg_o, next_bg_o : prefetched cell
//   attr_* / tile_* / color_* : memory read ports (data valid the cycle after enable)
module tile_fetcher
   import gpu_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_i,
   input  logic [CELL_W-1:0]   cell_i,
   input  logic [2:0]          row_i,
   input  logic                consume_i,
   output logic                busy_o,
   output logic                next_valid_o,
   output logic [7:0]          next_row_o,
   output rgb332_t             next_fg_o,
   output rgb332_t             next_bg_o,
   output logic                attr_re_o,
   output logic [ATTR_AW-1:0]  attr_addr_o,
   input  logic [7:0]          attr_rd_i,
   output logic                tile_re_o,
   output logic [TILE_AW-1:0]  tile_addr_o,
   input  logic [7:0]          tile_rd_i,
   output logic                color_re_o,
   output logic [COLOR_AW-1:0] color_addr_o,
   input  rgb332_t             color_rd_i
);

   fetch_state_e        state_q;
   logic [CELL_W-1:0]   cell_q;
   logic [2:0]          row_q;
   logic [3:0]          bg_idx_q;
   logic                next_valid_q;
   logic [7:0]          next_row_q;
   rgb332_t             next_fg_q, next_bg_q;
   logic                attr_re_q, tile_re_q, color_re_q;
   logic [ATTR_AW-1:0]  attr_addr_q;
   logic [TILE_AW-1:0]  tile_addr_q;
   logic [COLOR_AW-1:0] color_addr_q;

   // Each read is launched on entry to the state that owns it, so the data
   // seen in a state is the answer to the previous state's read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cell_q       <= '0;
         row_q        <= '0;
         bg_idx_q     <= '0;
         next_valid_q <= 1'b0;
         next_row_q   <= '0;
         next_fg_q    <= '0;
         next_bg_q    <= '0;
         attr_re_q    <= 1'b0;
         tile_re_q    <= 1'b0;
         color_re_q   <= 1'b0;
         attr_addr_q  <= '0;
         tile_addr_q  <= '0;
         color_addr_q <= '0;
      end else begin
         attr_re_q  <= 1'b0;
         tile_re_q  <= 1'b0;
         color_re_q <= 1'b0;
         if (consume_i) next_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  cell_q      <= cell_i;
                  row_q       <= row_i;
                  attr_re_q   <= 1'b1;
                  attr_addr_q <= {cell_i, 1'b0};
                  state_q     <= ST_IDX;
               end
            end
            ST_IDX: begin
               attr_re_q   <= 1'b1;
               attr_addr_q <= {cell_q, 1'b1};
               state_q     <= ST_COL;
            end
            ST_COL: begin            // tile index arrives
               tile_re_q   <= 1'b1;
               tile_addr_q <= {attr_rd_i, row_q};
               state_q     <= ST_ROW;
            end
            ST_ROW: begin            // colour byte arrives
               bg_idx_q     <= attr_rd_i[3:0];
               color_re_q   <= 1'b1;
               color_addr_q <= attr_rd_i[7:4];
               state_q      <= ST_FG;
            end
            ST_FG: begin             // tile row arrives
               next_row_q   <= tile_rd_i;
               color_re_q   <= 1'b1;
               color_addr_q <= bg_idx_q;
               state_q      <= ST_BG;
            end
            ST_BG: begin             // fg palette entry arrives
               next_fg_q <= color_rd_i;
               state_q   <= ST_DONE;
            end
            ST_DONE: begin           // bg palette entry arrives
               next_bg_q    <= color_rd_i;
               next_valid_q <= 1'b1;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy_o       = (state_q != ST_IDLE);
   assign next_valid_o = next_valid_q;
   assign next_row_o   = next_row_q;
   assign next_fg_o    = next_fg_q;
   assign next_bg_o    = next_bg_q;
   assign attr_re_o    = attr_re_q;
   assign attr_addr_o  = attr_addr_q;
   assign tile_re_o    = tile_re_q;
   assign tile_addr_o  = tile_addr_q;
   assign color_re_o   = color_re_q;
   assign color_addr_o = color_addr_q;

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: turns raster coordinates into one RGB332 pixel per pixel_en,
// from a 40x30 grid of 8x8 tiles doubled to 2x2 screen pixels.
// Ports:
//   clk, reset_n                    : clock, async active-low reset
//   pixel_en, hpos, vpos            : pixel strobe and raster position
//   active_in, hsync_in, vsync_in   : timing flags, delayed to the *_out flags
//   attribute/tile/color_memory_*   : synchronous memory read ports
//   rgb_out                         : pixel, registered on pixel_en
//   underrun                        : sticky underrun flag (macro builds only)
// Build option: define TILE_RENDERER_UNDERRUN_EN to add the underrun port and
// paint cells whose fetch missed its boundary with UNDERRUN_COLOR.
module tile_renderer
   import gpu_pkg::*;
#(
   parameter int            H_ACTIVE       = H_ACTIVE_DEF,
   parameter int            V_ACTIVE       = V_ACTIVE_DEF,
   parameter int            V_TOTAL        = V_TOTAL_DEF,
   parameter int            COLUMNS        = COLUMNS_DEF,
   parameter logic [7:0]    UNDERRUN_COLOR = 8'hE0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pixel_en,
   input  logic [9:0]          hpos,
   input  logic [9:0]          vpos,
   input  logic                active_in,
   input  logic                hsync_in,
   input  logic                vsync_in,
   output logic                attribute_memory_read_enable,
   output logic [ATTR_AW-1:0]  attribute_memory_read_addr,
   input  logic [7:0]          attribute_memory_read_data,
   output logic                tile_memory_read_enable,
   output logic [TILE_AW-1:0]  tile_memory_read_addr,
   input  logic [7:0]          tile_memory_read_data,
   output logic                color_memory_read_enable,
   output logic [COLOR_AW-1:0] color_memory_read_addr,
   input  logic [7:0]          color_memory_read_data,
`ifdef TILE_RENDERER_UNDERRUN_EN
   output logic                underrun,
`endif
   output logic [7:0]          rgb_out,
   output logic                active_out,
   output logic                hsync_out,
   output logic                vsync_out
);

`ifdef TILE_RENDERER_UNDERRUN_EN
   localparam bit UR_EN = 1'b1;
`else
   localparam bit UR_EN = 1'b0;
`endif

   // Fetcher interface
   logic              start;
   logic [CELL_W-1:0] start_cell;
   logic [2:0]        start_row;
   logic              busy;
   logic              next_valid;
   logic [7:0]        next_row;
   rgb332_t           next_fg, next_bg;

   // Current cell and output registers
   logic [7:0] cur_row_q;
   rgb332_t    cur_fg_q, cur_bg_q;
   logic       cell_ur_q;
   rgb332_t    rgb_q;
   logic       active_q, hsync_q, vsync_q;

   // Trigger / pixel path
   logic       boundary, line_pf, use_next, show_ur;
   logic [6:0] col_nxt;
   logic [9:0] v_nxt;
   logic [7:0] row_sel;
   rgb332_t    fg_sel, bg_sel, tile_pix, pix_d;

   always_comb begin
      boundary   = pixel_en && active_in && (hpos[3:0] == 4'd0);
      line_pf    = pixel_en && (hpos == 10'(H_ACTIVE));
      col_nxt    = {1'b0, hpos[9:4]} + 7'd1;
      v_nxt      = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
      start      = 1'b0;
      start_cell = '0;
      start_row  = '0;
      if (boundary && (int'(col_nxt) < COLUMNS)) begin
         start      = 1'b1;
         start_cell = cell_index(vpos[8:4], col_nxt, COLUMNS);
         start_row  = vpos[3:1];
      end else if (line_pf && (int'(v_nxt) < V_ACTIVE)) begin
         start      = 1'b1;
         start_cell = cell_index(v_nxt[8:4], 7'd0, COLUMNS);
         start_row  = v_nxt[3:1];
      end

      // The boundary pixel must already show the cell being loaded this edge.
      use_next = boundary && next_valid;
      row_sel  = use_next ? next_row : cur_row_q;
      fg_sel   = use_next ? next_fg  : cur_fg_q;
      bg_sel   = use_next ? next_bg  : cur_bg_q;
      tile_pix = row_sel[3'd7 - hpos[3:1]] ? fg_sel : bg_sel;

      // An underrun cell stays flagged until the next boundary re-evaluates it.
      show_ur  = UR_EN && (boundary ? !next_valid : cell_ur_q);
      pix_d    = !active_in ? 8'h00 : (show_ur ? UNDERRUN_COLOR : tile_pix);
   end

   tile_fetcher u_fetch (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (start),
      .cell_i       (start_cell),
      .row_i        (start_row),
      .consume_i    (use_next),
      .busy_o       (busy),
      .next_valid_o (next_valid),
      .next_row_o   (next_row),
      .next_fg_o    (next_fg),
      .next_bg_o    (next_bg),
      .attr_re_o    (attribute_memory_read_enable),
      .attr_addr_o  (attribute_memory_read_addr),
      .attr_rd_i    (attribute_memory_read_data),
      .tile_re_o    (tile_memory_read_enable),
      .tile_addr_o  (tile_memory_read_addr),
      .tile_rd_i    (tile_memory_read_data),
      .color_re_o   (color_memory_read_enable),
      .color_addr_o (color_memory_read_addr),
      .color_rd_i   (color_memory_read_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_row_q <= '0;
         cur_fg_q  <= '0;
         cur_bg_q  <= '0;
         cell_ur_q <= 1'b0;
         rgb_q     <= '0;
         active_q  <= 1'b0;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
      end else if (pixel_en) begin
         rgb_q    <= pix_d;
         active_q <= active_in;
         hsync_q  <= hsync_in;
         vsync_q  <= vsync_in;
         if (boundary) begin
            cell_ur_q <= !next_valid;
            if (next_valid) begin
               cur_row_q <= next_row;
               cur_fg_q  <= next_fg;
               cur_bg_q  <= next_bg;
            end
         end
      end
   end

`ifdef TILE_RENDERER_UNDERRUN_EN
   logic underrun_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    underrun_q <= 1'b0;
      else if (boundary && !next_valid) underrun_q <= 1'b1;
   end
   assign underrun = underrun_q;
`endif

   assign rgb_out    = rgb_q;
   assign active_out = active_q;
   assign hsync_out  = hsync_q;
   assign vsync_out  = vsync_q;

endmodule
